// File: rtl/vec_lsu_pkg.sv
// Shared types and constants for the strided vector load/store unit.
package vec_lsu_pkg;

  typedef enum logic [1:0] {
    SEW_8   = 2'd0,
    SEW_16  = 2'd1,
    SEW_32  = 2'd2,
    SEW_ILL = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Byte-enable patterns for an element sitting at byte offset 0.
  localparam logic [3:0] STRB_8  = 4'b0001;
  localparam logic [3:0] STRB_16 = 4'b0011;
  localparam logic [3:0] STRB_32 = 4'b1111;

  // Element size in bytes; the illegal encoding maps to 4 so that the
  // alignment mask stays well defined (the command is rejected anyway).
  function automatic logic [2:0] SEW_BYTES(input logic [1:0] sew);
    case (sew)
      SEW_8:   SEW_BYTES = 3'd1;
      SEW_16:  SEW_BYTES = 3'd2;
      default: SEW_BYTES = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/vec_strided_lsu_if.sv
// Vector memory port: one word-sized request per valid/ready handshake.
interface vec_strided_lsu_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/vec_lane_align.sv
// Byte-lane steering between a 32-bit memory word and one vector element.
// Load side: pull the element at byte offset `off` out of `word`, zero-extended.
// Store side: replicate `elem` across the word and build the byte enables.
module vec_lane_align
  import vec_lsu_pkg::*;
(
  input  logic [1:0]  sew,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] elem,
  output logic [31:0] ld_elem,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb
);

  logic [31:0] shifted;

  // Select the element lane and the matching store pattern for this SEW.
  always_comb begin
    shifted  = word >> {off, 3'b000};
    ld_elem  = shifted;
    st_wdata = elem;
    st_wstrb = STRB_32;
    case (sew)
      SEW_8: begin
        ld_elem  = {24'h0, shifted[7:0]};
        st_wdata = {4{elem[7:0]}};
        st_wstrb = STRB_8 << off;
      end
      SEW_16: begin
        ld_elem  = {16'h0, shifted[15:0]};
        st_wdata = {2{elem[15:0]}};
        st_wstrb = STRB_16 << off;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vec_strided_lsu.sv
// Strided vector load/store unit. Walks vl elements one memory word at a
// time; loads gather into a VLEN buffer written back to the VRF once,
// stores stream out of the register value captured at command accept.
module vec_strided_lsu
  import vec_lsu_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_store,
  input  logic [31:0]         cmd_base,
  input  logic [31:0]         cmd_stride,
  input  logic [7:0]          cmd_vl,
  input  logic [1:0]          cmd_sew,
  input  logic [4:0]          cmd_vd,
  input  logic [VLEN-1:0]     cmd_vs_data,
  vec_strided_lsu_if.master   mem,
  output logic                vrf_we,
  output logic [4:0]          vrf_waddr,
  output logic [VLEN-1:0]     vrf_wdata,
  output logic                done,
  output logic                err
);

  localparam int NB = VLEN / 8;
  localparam int BW = $clog2(NB);

  state_e state, state_nx;

  logic                 store_q;
  logic [31:0]          addr;
  logic [31:0]          stride;
  logic [7:0]           vl_q;
  logic [7:0]           idx;
  logic [1:0]           sew_q;
  logic [4:0]           vd_q;
  logic                 err_q;
  logic [VLEN-1:0]      st_data;
  logic [NB-1:0][7:0]   ld_buf;

  logic                 req_valid;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic [3:0]           req_wstrb;

  logic [7:0]           vl_clamp;
  logic                 cmd_bad;
  logic [2:0]           cur_bytes;
  logic                 elem_misalign;
  logic                 issue;
  logic                 elem_fault;
  logic                 fire;
  logic                 last;

  logic [31:0]          ld_elem;
  logic [31:0]          st_wdata;
  logic [3:0]           st_wstrb;

  vec_lane_align u_align (
    .sew      (sew_q),
    .off      (addr[1:0]),
    .word     (mem.mem_rdata),
    .elem     (st_data[31:0]),
    .ld_elem  (ld_elem),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb)
  );

  // Command-side decode: clamp vl to VLEN/SEW and flag illegal commands.
  always_comb begin
    int vlmax;
    logic [1:0] mask;
    case (cmd_sew)
      SEW_8:   vlmax = VLEN / 8;
      SEW_16:  vlmax = VLEN / 16;
      default: vlmax = VLEN / 32;
    endcase
    vl_clamp = (int'(cmd_vl) > vlmax) ? 8'(vlmax) : cmd_vl;
    mask     = 2'(SEW_BYTES(cmd_sew) - 3'd1);
    cmd_bad  = (cmd_sew == SEW_ILL) || ((cmd_base[1:0] & mask) != 2'b00);
  end

  // Per-element handshake qualifiers. A request is launched only from the
  // idle half of an element slot, which guarantees a gap between requests.
  always_comb begin
    cur_bytes     = SEW_BYTES(sew_q);
    elem_misalign = (addr[1:0] & 2'(cur_bytes - 3'd1)) != 2'b00;
    issue         = (state == S_REQ) && !req_valid && !elem_misalign;
    elem_fault    = (state == S_REQ) && !req_valid && elem_misalign;
    fire          = (state == S_REQ) && req_valid && mem.mem_ready;
    last          = (idx == vl_q - 8'd1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad || cmd_vl == 8'd0) state_nx = S_DONE;
          else                           state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (elem_fault)       state_nx = S_DONE;
        else if (fire && last) state_nx = store_q ? S_DONE : S_WB;
      end
      S_WB:    state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Command capture, element walk, load gather and memory request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_q   <= 1'b0;
      addr      <= '0;
      stride    <= '0;
      vl_q      <= '0;
      idx       <= '0;
      sew_q     <= '0;
      vd_q      <= '0;
      err_q     <= 1'b0;
      st_data   <= '0;
      ld_buf    <= '0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            store_q <= cmd_store;
            addr    <= cmd_base;
            stride  <= cmd_stride;
            vl_q    <= vl_clamp;
            idx     <= '0;
            sew_q   <= cmd_sew;
            vd_q    <= cmd_vd;
            err_q   <= cmd_bad;
            st_data <= cmd_vs_data;
            ld_buf  <= '0;
          end
        end
        S_REQ: begin
          if (issue) begin
            req_valid <= 1'b1;
            req_addr  <= {addr[31:2], 2'b00};
            req_wdata <= store_q ? st_wdata : 32'h0;
            req_wstrb <= store_q ? st_wstrb : 4'h0;
          end
          if (elem_fault) err_q <= 1'b1;
          if (fire) begin
            req_valid <= 1'b0;
            req_wstrb <= 4'h0;
            idx       <= idx + 8'd1;
            addr      <= addr + stride;
            if (store_q) begin
              st_data <= st_data >> {cur_bytes, 3'b000};
            end else begin
              for (int k = 0; k < 4; k++) begin
                if (k < int'(cur_bytes))
                  ld_buf[BW'(int'(idx) * int'(cur_bytes) + k)] <= ld_elem[k*8 +: 8];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready     = (state == S_IDLE) && !reset;
  assign mem.mem_valid = req_valid;
  assign mem.mem_addr  = req_addr;
  assign mem.mem_wdata = req_wdata;
  assign mem.mem_wstrb = req_wstrb;
  assign vrf_we        = (state == S_WB);
  assign vrf_waddr     = vd_q;
  assign vrf_wdata     = (state == S_WB) ? ld_buf : '0;
  assign done          = (state == S_DONE);
  assign err           = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_vec_strided_lsu.sv
// Directed bench for vec_strided_lsu with a zero-wait word memory model.
module tb_vec_strided_lsu;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready, cmd_store;
  logic [31:0]  cmd_base, cmd_stride;
  logic [7:0]   cmd_vl;
  logic [1:0]   cmd_sew;
  logic [4:0]   cmd_vd;
  logic [127:0] cmd_vs_data;
  logic         vrf_we, done, err;
  logic [4:0]   vrf_waddr;
  logic [127:0] vrf_wdata;

  vec_strided_lsu_if mif ();

  vec_strided_lsu #(.VLEN(128)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_store   (cmd_store),
    .cmd_base    (cmd_base),
    .cmd_stride  (cmd_stride),
    .cmd_vl      (cmd_vl),
    .cmd_sew     (cmd_sew),
    .cmd_vd      (cmd_vd),
    .cmd_vs_data (cmd_vs_data),
    .mem         (mif),
    .vrf_we      (vrf_we),
    .vrf_waddr   (vrf_waddr),
    .vrf_wdata   (vrf_wdata),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Memory model: answers in the same cycle as the request unless throttled.
  logic [31:0] words [256];
  int          ready_limit = 1 << 30;
  int          fire_cnt = 0, vcyc = 0, gap_viol = 0, vrf_cnt = 0, done_cnt = 0;
  logic        prev_fire = 1'b0;
  logic [127:0] vrf_last = '0;
  logic [4:0]   vrf_addr_last = '0;
  logic [31:0] la [$];
  logic [31:0] lw [$];
  logic [3:0]  ls [$];

  assign mif.mem_ready = mif.mem_valid && (fire_cnt < ready_limit);
  assign mif.mem_rdata = words[mif.mem_addr[9:2]];

  // Bus/VRF monitor.
  always @(posedge clk) begin
    if (reset) begin
      prev_fire <= 1'b0;
    end else begin
      if (mif.mem_valid) vcyc <= vcyc + 1;
      if (prev_fire && mif.mem_valid) gap_viol <= gap_viol + 1;
      prev_fire <= mif.mem_valid && mif.mem_ready;
      if (mif.mem_valid && mif.mem_ready) begin
        la.push_back(mif.mem_addr);
        lw.push_back(mif.mem_wdata);
        ls.push_back(mif.mem_wstrb);
        fire_cnt <= fire_cnt + 1;
      end
      if (vrf_we) begin
        vrf_cnt       <= vrf_cnt + 1;
        vrf_last      <= vrf_wdata;
        vrf_addr_last <= vrf_waddr;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int checks = 0, errors = 0;
  int b_fire, b_vcyc, b_vrf, b_done;
  int lat;
  logic err_at_done;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one command, then hold cmd_valid with junk fields until done so
  // that anything sampled outside IDLE would corrupt the result.
  task automatic run(input logic st, input logic [31:0] base, input logic [31:0] stride,
                     input logic [7:0] vl, input logic [1:0] sew, input logic [4:0] vd,
                     input logic [127:0] vs);
    b_fire = fire_cnt; b_vcyc = vcyc; b_vrf = vrf_cnt; b_done = done_cnt;
    cmd_store = st; cmd_base = base; cmd_stride = stride; cmd_vl = vl;
    cmd_sew = sew; cmd_vd = vd; cmd_vs_data = vs; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_store = ~st; cmd_base = 32'h1234_5679; cmd_stride = 32'h7;
    cmd_vl = 8'hff; cmd_sew = 2'd3; cmd_vd = 5'd31; cmd_vs_data = '1;
    lat = 0;
    err_at_done = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (done) begin
        lat = n;
        err_at_done = err;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("done_seen", 1'(lat != 0), 1'b1);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) words[i] = 32'h0;
    words[100] = 32'h04030201; words[101] = 32'h08070605;
    words[102] = 32'h0c0b0a09; words[103] = 32'h000f0e0d;
    words[104] = 32'h0a090807; words[105] = 32'h0807060b;
    words[106] = 32'h0c0b0a0c; words[107] = 32'h000f0e0d;

    reset = 1'b1; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = '0;
    cmd_stride = '0; cmd_vl = '0; cmd_sew = '0; cmd_vd = '0; cmd_vs_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_mem_valid", mif.mem_valid, 1'b0);
    chk("rst_mem_wstrb", mif.mem_wstrb, 4'h0);
    chk("rst_mem_addr", mif.mem_addr, 32'h0);
    chk("rst_mem_wdata", mif.mem_wdata, 32'h0);
    chk("rst_vrf_we", vrf_we, 1'b0);
    chk("rst_vrf_wdata", vrf_wdata, 128'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Load SEW16, stride 4, vl 8.
    run(1'b0, 32'd400, 32'd4, 8'd8, 2'd1, 5'd5, '0);
    chk("t1_reads", fire_cnt - b_fire, 8);
    for (int i = 0; i < 8; i++) chk("t1_addr", la[b_fire + i], 32'(400 + 4 * i));
    chk("t1_wstrb", ls[b_fire], 4'h0);
    chk("t1_vrf_cnt", vrf_cnt - b_vrf, 1);
    chk("t1_vrf_waddr", vrf_addr_last, 5'd5);
    chk("t1_vrf_wdata", vrf_last, 128'h0e0d_0a0c_060b_0807_0e0d_0a09_0605_0201);
    chk("t1_err", err_at_done, 1'b0);
    chk("t1_latency", lat, 18);

    // Load SEW8, stride 1, vl 4: all bytes from one word.
    run(1'b0, 32'd400, 32'd1, 8'd4, 2'd0, 5'd2, '0);
    chk("t2_reads", fire_cnt - b_fire, 4);
    for (int i = 0; i < 4; i++) chk("t2_addr", la[b_fire + i], 32'd400);
    chk("t2_vrf_wdata", vrf_last, 128'h04030201);
    chk("t2_latency", lat, 10);

    // Load SEW32, negative stride.
    run(1'b0, 32'd412, 32'hFFFF_FFFC, 8'd2, 2'd2, 5'd7, '0);
    chk("t3_addr0", la[b_fire], 32'd412);
    chk("t3_addr1", la[b_fire + 1], 32'd408);
    chk("t3_vrf_wdata", vrf_last, 128'h0c0b0a09_000f0e0d);

    // Store SEW16, stride 6: second element lands on the upper half-word.
    run(1'b1, 32'd600, 32'd6, 8'd2, 2'd1, 5'd3, 128'hBBBB_AAAA);
    chk("t4_writes", fire_cnt - b_fire, 2);
    chk("t4_addr0", la[b_fire], 32'd600);
    chk("t4_wstrb0", ls[b_fire], 4'b0011);
    chk("t4_wdata0", lw[b_fire], 32'hAAAA_AAAA);
    chk("t4_addr1", la[b_fire + 1], 32'd604);
    chk("t4_wstrb1", ls[b_fire + 1], 4'b1100);
    chk("t4_wdata1", lw[b_fire + 1], 32'hBBBB_BBBB);
    chk("t4_no_vrf", vrf_cnt - b_vrf, 0);
    chk("t4_err", err_at_done, 1'b0);
    chk("t4_latency", lat, 5);

    // vl = 0.
    run(1'b0, 32'd400, 32'd4, 8'd0, 2'd2, 5'd1, '0);
    chk("vl0_latency", lat, 1);
    chk("vl0_no_valid", vcyc - b_vcyc, 0);
    chk("vl0_no_vrf", vrf_cnt - b_vrf, 0);
    chk("vl0_err", err_at_done, 1'b0);

    // Misaligned base.
    run(1'b0, 32'd401, 32'd2, 8'd4, 2'd1, 5'd1, '0);
    chk("mis_err", err_at_done, 1'b1);
    chk("mis_latency", lat, 1);
    chk("mis_no_valid", vcyc - b_vcyc, 0);
    chk("mis_no_vrf", vrf_cnt - b_vrf, 0);

    // Illegal SEW.
    run(1'b1, 32'd400, 32'd4, 8'd2, 2'd3, 5'd1, '0);
    chk("sew3_err", err_at_done, 1'b1);
    chk("sew3_no_valid", vcyc - b_vcyc, 0);

    // Second element misaligned: one access, then abort without writeback.
    run(1'b0, 32'd400, 32'd1, 8'd3, 2'd1, 5'd1, '0);
    chk("elem_mis_err", err_at_done, 1'b1);
    chk("elem_mis_reads", fire_cnt - b_fire, 1);
    chk("elem_mis_no_vrf", vrf_cnt - b_vrf, 0);
    chk("elem_mis_latency", lat, 4);

    // vl larger than VLEN/SEW is clamped to 4 words.
    run(1'b0, 32'd400, 32'd4, 8'd10, 2'd2, 5'd9, '0);
    chk("clamp_reads", fire_cnt - b_fire, 4);
    chk("clamp_vrf_wdata", vrf_last, 128'h000f0e0d_0c0b0a09_08070605_04030201);
    chk("clamp_latency", lat, 10);

    // Reset while the third element is stalled on mem_ready.
    b_fire = fire_cnt;
    ready_limit = fire_cnt + 2;
    cmd_store = 1'b0; cmd_base = 32'd400; cmd_stride = 32'd4; cmd_vl = 8'd4;
    cmd_sew = 2'd2; cmd_vd = 5'd4; cmd_vs_data = '0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 50; n++) begin
      if (fire_cnt == b_fire + 2 && mif.mem_valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    chk("rm_stalled", 1'(lat != 0), 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("rm_mem_valid", mif.mem_valid, 1'b0);
    chk("rm_cmd_ready_in_rst", cmd_ready, 1'b0);
    reset = 1'b0;
    ready_limit = 1 << 30;
    b_vrf = vrf_cnt; b_done = done_cnt; b_vcyc = vcyc;
    repeat (6) @(negedge clk);
    chk("rm_no_vrf", vrf_cnt - b_vrf, 0);
    chk("rm_no_done", done_cnt - b_done, 0);
    chk("rm_no_valid", vcyc - b_vcyc, 0);
    chk("rm_cmd_ready", cmd_ready, 1'b1);

    run(1'b0, 32'd400, 32'd1, 8'd4, 2'd0, 5'd2, '0);
    chk("rm_after_vrf_wdata", vrf_last, 128'h04030201);
    chk("rm_after_err", err_at_done, 1'b0);

    chk("no_back_to_back", gap_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
